// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - multi-requester arbiter sharing one combinational ALU (option: ALU_ARBITER_ROUND_ROBIN_EN)
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic [WIDTH-1:0]         alu_operand_a,
    output logic [WIDTH-1:0]         alu_operand_b,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     busy
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   grant;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  result;
    logic [IDXW-1:0]   win;
    logic              found;
    logic              accept;
    logic              resp_done;
    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];

    // Unpack the flat operand buses so the winner can index them directly
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_valid[IDXW'(j)]) begin
                found = 1'b1;
                win   = IDXW'(j);
            end
        end
    end

    // Pointer moves past the granted requester once its response is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (resp_done) begin
            ptr <= (grant == IDXW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end
`else
    // Fixed priority: lowest valid index wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDXW'(k)]) begin
                found = 1'b1;
                win   = IDXW'(k);
            end
        end
    end
`endif

    assign accept    = (state == IDLE) && found;
    assign resp_done = (state == RESP) && resp_ready[grant];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one EXEC cycle, RESP held until the granted requester takes it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch grant and operands on accept, capture the ALU output at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                grant <= win;
                op_a  <= a_arr[win];
                op_b  <= b_arr[win];
            end
            if (state == EXEC) begin
                result <= alu_result;
            end
        end
    end

    // Outputs; req_ready is combinational so it is also masked by reset
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (rst_n && accept) begin
            req_ready = NUM_REQ'(1) << win;
        end
        if (state == RESP) begin
            resp_valid = NUM_REQ'(1) << grant;
        end
    end

    assign resp_result   = result;
    assign alu_operand_a = op_a;
    assign alu_operand_b = op_b;
    assign busy          = (state != IDLE);

endmodule
